operand_sweep: RTL
==================

# operand_sweep

Sequential driver that sits directly upstream of the 2-bit combinational function stage (inputs `a[1:0]`, `b[1:0]`, output `c[1:0]`). On `start` it steps `{a,b}` through all 16 operand combinations and waits a programmable settle time after each. It then captures the stage's `c` into a 32-bit result table, exposing the function's full truth table for lab checking. It owns both the operand generation and the result capture for that stage.

## Interface
- `SETTLE`, default 1: cycles operands are held before capture; legal range 1..15.

- `clk` in, 1: sole clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `start` in, 1: begin a sweep; sampled only in IDLE.
- `a` out, 2: operand to function stage, equal to `idx[3:2]`.
- `b` out, 2: operand to function stage, equal to `idx[1:0]`.
- `c` in, 2: result from function stage.
- `busy` out, 1: high in SETTLE and CAPTURE.
- `done` out, 1: one-cycle pulse in the DONE state.
- `valid` out, 1: table holds a complete sweep.
- `table_out` out, 32: bits `[2k+1:2k]` hold `c` captured for index k = `{a,b}`.

## Operation
- State register has four states: IDLE, SETTLE, CAPTURE, DONE.
- Internal registers:
  - `idx`: 4 bits.
  - `cnt`: 4 bits.
  - table: 32 bits.
- `a` and `b` are combinational from `idx` in every state.
- IDLE:
  - `start`=1 → SETTLE.
  - `idx`←0, `cnt`←0, table←0, `valid`←0.
- SETTLE:
  - `cnt` increments each cycle.
  - When `cnt`==SETTLE-1 → CAPTURE.
- CAPTURE:
  - `table[2*idx +: 2]`←`c`.
  - If `idx`==15 → DONE.
  - Otherwise `idx`←`idx`+1, `cnt`←0, → SETTLE.
- DONE:
  - `done`=1, `valid`←1, `idx`←0, → IDLE.
- `start` is ignored outside IDLE; there is no queueing.
- The table is only written in CAPTURE. It holds its value in IDLE and DONE until the next accepted `start` clears it.
- `c` is never sampled outside CAPTURE.

## Timing
- Reset values: state=IDLE, `idx`=0, `cnt`=0, `a`=0, `b`=0, `busy`=0, `done`=0, `valid`=0, `table_out`=0.
- Each index occupies SETTLE+1 cycles: SETTLE cycles in SETTLE, then 1 in CAPTURE.
- `start` is accepted at edge E0. `done` is high during cycle 16·(SETTLE+1)+1 after E0 (cycle 33 for SETTLE=1).
- `valid` rises on the edge that ends DONE.
- `busy` is high from the cycle after E0 through the last CAPTURE cycle.
- `a`/`b` change only on the edge leaving CAPTURE, so `c` has had SETTLE full cycles to settle when sampled.
- Wrap-around: `idx`=15 never increments to 0 via CAPTURE. It returns to 0 only in DONE.
- `start` asserted in the same cycle as `done` is ignored. The next `start` is accepted in IDLE one cycle later.
- `rst` mid-sweep immediately forces all reset values. The partial table is discarded and `valid`=0.

## Structure
- Shared include file holds:
  - The 2-bit state encodings: IDLE=0, SETTLE=1, CAPTURE=2, DONE=3.
  - The table width constant (32).
- No sub-module inside `operand_sweep`.
- The function stage is instantiated beside it in the lab top-level, not inside it.
- Bench top connects `a`/`b`/`c` of both blocks directly.

## Test plan
- Reset then idle: hold `rst`=1 then release, no `start` → all outputs 0 for 50 cycles.
- Full sweep against the existing function stage, SETTLE=1: pulse `start` → `done` in cycle 33, `table_out`=32'h5A5AF5C0, `valid`=1.
- Stub stage with c=a^b, SETTLE=3:
  - Pulse `start` → `done` in cycle 65.
  - `table_out`=32'h1B4EB1E4 (entry k = `k[3:2]`^`k[1:0]`).
- Ignored start: pulse `start` at cycles 5 and 20 of a sweep → single `done`, same table, cycle count unchanged.
- Mid-sweep reset: assert `rst` during idx=7 CAPTURE → same cycle `busy`=0, `table_out`=0, `a`=`b`=0. A new sweep then completes normally.
- Back-to-back sweeps:
  - `start` held high continuously → sweeps restart every 34 cycles (SETTLE=1).
  - `valid` drops for each sweep and `table_out` clears to 0 at each restart.

Source files
------------

// File: rtl/operand_sweep_pkg.sv
// ============================================================================
// Module      : operand_sweep_pkg
// Description : Shared definitions for the operand sweep driver: the 2-bit
//               state encoding and the width of the captured result table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_sweep_pkg;

  // One 2-bit result per {a,b} combination: 16 entries x 2 bits.
  localparam int TABLE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/operand_sweep.sv
// ============================================================================
// Module      : operand_sweep
// Description : Drives a 2-bit combinational function stage through all 16
//               {a,b} operand combinations, waits SETTLE cycles after each
//               change, captures the stage's c output into a 32-bit table.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   SETTLE     - cycles operands are held before capture (legal 1..15)
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - begin a sweep; sampled only in IDLE
//   a, b       - operands to the function stage ({a,b} = current index)
//   c          - result returned by the function stage
//   busy       - high while in SETTLE or CAPTURE
//   done       - one-cycle pulse in the DONE state
//   valid      - table_out holds a complete sweep
//   table_out  - bits [2k+1:2k] hold c captured for index k = {a,b}
// ============================================================================
`default_nettype none

module operand_sweep
  import operand_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [1:0]         a,
  output logic [1:0]         b,
  input  logic [1:0]         c,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic [TABLE_W-1:0] table_out
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] IDX_LAST    = 4'hF;

  state_e               state_q, state_d;
  logic [3:0]           idx_q,   idx_d;
  logic [3:0]           cnt_q,   cnt_d;
  logic [TABLE_W-1:0]   table_q, table_d;
  logic                 valid_q, valid_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic [4:0]           bit_sel;

  // Bit offset of the current index's 2-bit entry in the table.
  assign bit_sel = {idx_q, 1'b0};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        // Clearing happens only on an accepted start so a finished table
        // stays readable while idling.
        if (start) begin
          state_d = ST_SETTLE;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
          table_d = '0;
          valid_d = 1'b0;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        table_d[bit_sel +: 2] = c;
        // Index 15 never wraps here; it returns to 0 only via DONE.
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = 4'd0;
          state_d = ST_SETTLE;
        end
      end

      ST_DONE: begin
        valid_d = 1'b1;
        idx_d   = 4'd0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      table_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Operands follow the index directly, so they only move on the edge that
  // leaves CAPTURE (or DONE, which returns idx to 0).
  assign a         = idx_q[3:2];
  assign b         = idx_q[1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign valid     = valid_q;
  assign table_out = table_q;

endmodule

`default_nettype wire
